mac_feeder: RTL and testbench
=============================

// Module: mac_feeder
// PURPOSE
//  Operand sequencer that drives the MAC accumulator (En/Clr/Ain/Bin in, Cout out).
//  Per job: clears the MAC, streams VEC_LEN (A,B) operand pairs from two ready/valid
//  streams into it, waits out the MAC pipeline, then returns the dot product on a
//  ready/valid result port. Sits between the operand buffers and the MAC datapath.
// PARAMETERS
//  DATA_WIDTH      8   operand width; result width is 3*DATA_WIDTH (matches MAC)
//  VEC_LEN         8   operand pairs per job, >=1
//  PIPELINE_DELAY  1   MAC En-to-accumulate delay in cycles (same value as the MAC)
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       begin a job; sampled only in IDLE
//  busy       out  1       high in any state other than IDLE
//  a_valid    in   1       A operand valid
//  a_ready    out  1       A operand consumed
//  a_data     in   DW      A operand
//  b_valid    in   1       B operand valid
//  b_ready    out  1       B operand consumed
//  b_data     in   DW      B operand
//  mac_en     out  1       to MAC En (registered)
//  mac_clr    out  1       to MAC Clr (registered)
//  mac_a      out  DW      to MAC Ain (registered)
//  mac_b      out  DW      to MAC Bin (registered)
//  mac_cout   in   3*DW    from MAC Cout
//  res_valid  out  1       result valid, held until accepted
//  res_ready  in   1       result accepted
//  res_data   out  3*DW    captured dot product
//  done       out  1       one-cycle pulse on result handshake
// BEHAVIOUR
//  - Reset: state=IDLE; busy, a_ready, b_ready, mac_en, mac_clr, res_valid, done = 0;
//    mac_a, mac_b, res_data, beat/drain counters = 0. Reset mid-job aborts it.
//  - FSM IDLE -> CLEAR -> FEED -> DRAIN -> RESULT -> IDLE.
//  - IDLE: start=1 -> CLEAR. start in any other state ignored.
//  - CLEAR: one cycle; mac_clr registered high for exactly the following cycle; -> FEED.
//  - FEED: beat = a_valid & b_valid. a_ready = b_ready = beat & (state==FEED), comb.
//    Both streams consumed together; one valid alone consumes nothing. On beat:
//    mac_a<=a_data, mac_b<=b_data, mac_en<=1 next cycle; else mac_en<=0 (mac_a/b hold).
//    Beat counter width $clog2(VEC_LEN+1); beat VEC_LEN -> DRAIN, counter cleared.
//  - DRAIN: exactly PIPELINE_DELAY+2 cycles (output reg + MAC delay + Cout reg);
//    a/b_ready=0, mac_en=0 after first DRAIN cycle. On final DRAIN edge:
//    res_data<=mac_cout, res_valid<=1, -> RESULT.
//  - RESULT: res_valid=1, res_data stable until res_valid&res_ready; on that cycle
//    -> IDLE, res_valid<=0, done<=1 for one cycle. res_ready while res_valid=0 ignored.
//  - Latency, no stalls: start to res_valid = VEC_LEN+PIPELINE_DELAY+4 cycles.
//  - No arithmetic beyond counters; accumulation width/overflow owned by the MAC.
//  - VEC_LEN=1: single beat then DRAIN. New start accepted the cycle after done.
// CONFIGURATION
//  MAC_FEEDER_ABORT_EN defined: adds input abort (1b) and output aborted (1b).
//    abort=1 in any non-IDLE state -> IDLE next cycle, mac_clr<=1 one cycle,
//    mac_en<=0, res_valid<=0, aborted pulses one cycle, done not pulsed,
//    ready outputs 0 that cycle. abort in IDLE ignored; abort beats start.
//  Not defined: ports absent, jobs run to completion.
// TESTING (DATA_WIDTH=8, VEC_LEN=4, PIPELINE_DELAY=1, bench MAC model with delay 1)
//  1 A={1,2,3,4}, B={5,6,7,8}, valids always high, res_ready=1 -> res_data=70,
//    res_valid at start+9, done one cycle, exactly one mac_clr pulse.
//  2 A=B={255 x4} -> res_data=260100 (0x03F804); no truncation.
//  3 Stall: a_valid low alternate cycles, b_valid always high -> only 4 joint beats,
//    mac_en count=4, res_data=70; no B consumed without matching A.
//  4 Backpressure: res_ready low 10 cycles in RESULT -> res_valid held, res_data
//    stable, start pulses ignored, done only after accept.
//  5 Back-to-back: job1 as test 1, job2 A=B={1,1,1,1} -> job2 res_data=4 (clear works).
//  6 rst_n low mid-FEED after 2 beats -> all outputs at reset values asynchronously;
//    next job gives 70. With MAC_FEEDER_ABORT_EN: abort in DRAIN -> aborted pulse,
//    no res_valid, next job gives 70.

Source files
------------

// File: rtl/mac_feeder.sv
// mac_feeder
//
// Operand sequencer in front of the MAC accumulator. For each job it clears
// the MAC, streams VEC_LEN joint (A,B) operand beats into it, waits for the
// MAC pipeline to drain, and then presents the dot product on a ready/valid
// result port. The MAC owns all arithmetic. This block only counts beats and
// drain cycles.
//
// Optional feature macro: MAC_FEEDER_ABORT_EN
//   When the macro is defined, the block gains an abort input and an aborted
//   output. Abort cancels a running job. When the macro is undefined, those
//   ports do not exist and every job runs to completion.
//
// Parameters
//   DATA_WIDTH      operand width; the result width is 3*DATA_WIDTH
//   VEC_LEN         operand pairs per job (>= 1)
//   PIPELINE_DELAY  MAC En-to-accumulate delay in cycles
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   start               begin a job; sampled only while idle
//   busy                high whenever a job is in progress
//   a_valid/a_ready/a_data   A operand stream
//   b_valid/b_ready/b_data   B operand stream (consumed jointly with A)
//   mac_en/mac_clr/mac_a/mac_b   registered drive to the MAC
//   mac_cout            accumulator value from the MAC
//   res_valid/res_ready/res_data   result stream, held until accepted
//   done                one-cycle pulse on the result handshake
//   abort/aborted       (MAC_FEEDER_ABORT_EN only) cancel request and its
//                       one-cycle acknowledge pulse

`timescale 1ns/1ps

module mac_feeder #(
  parameter int DATA_WIDTH     = 8,
  parameter int VEC_LEN        = 8,
  parameter int PIPELINE_DELAY = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [DATA_WIDTH-1:0]     a_data,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [DATA_WIDTH-1:0]     b_data,
  output logic                      mac_en,
  output logic                      mac_clr,
  output logic [DATA_WIDTH-1:0]     mac_a,
  output logic [DATA_WIDTH-1:0]     mac_b,
  input  logic [3*DATA_WIDTH-1:0]   mac_cout,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [3*DATA_WIDTH-1:0]   res_data,
  output logic                      done
`ifdef MAC_FEEDER_ABORT_EN
  ,
  input  logic                      abort,
  output logic                      aborted
`endif
);

  localparam int RES_W   = 3 * DATA_WIDTH;
  localparam int BEAT_W  = $clog2(VEC_LEN + 1);
  localparam int DRAIN_W = $clog2(PIPELINE_DELAY + 2);

  // The drain lasts PIPELINE_DELAY+2 cycles. Those cycles cover our own
  // output register, the MAC delay, and the MAC Cout register. mac_cout
  // therefore holds the final sum on the last drain edge.
  localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(VEC_LEN - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPELINE_DELAY + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    FEED   = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } state_t;

  state_t               state;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic                 kill;
  logic                 beat;

  // A cancel request only counts while a job is running.
`ifdef MAC_FEEDER_ABORT_EN
  assign kill = abort & (state != IDLE);
`else
  assign kill = 1'b0;
`endif

  // A and B always move together. A lone valid never consumes anything,
  // and nothing is consumed in the cycle a job is cancelled.
  assign beat    = a_valid & b_valid & (state == FEED) & ~kill;
  assign a_ready = beat;
  assign b_ready = beat;
  assign busy    = (state != IDLE);

  // Job sequencer with all MAC-facing and result outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      done      <= 1'b0;
`ifdef MAC_FEEDER_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      mac_clr <= 1'b0;
      done    <= 1'b0;
`ifdef MAC_FEEDER_ABORT_EN
      aborted <= 1'b0;
`endif
      if (kill) begin
        // Clear the MAC on the way out so no partial sum leaks into the next job.
        state     <= IDLE;
        beat_cnt  <= '0;
        drain_cnt <= '0;
        mac_en    <= 1'b0;
        mac_clr   <= 1'b1;
        res_valid <= 1'b0;
`ifdef MAC_FEEDER_ABORT_EN
        aborted   <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE: begin
            mac_en <= 1'b0;
            if (start) begin
              state <= CLEAR;
            end
          end

          CLEAR: begin
            mac_en   <= 1'b0;
            mac_clr  <= 1'b1;
            beat_cnt <= '0;
            state    <= FEED;
          end

          FEED: begin
            if (beat) begin
              mac_a  <= a_data;
              mac_b  <= b_data;
              mac_en <= 1'b1;
              if (beat_cnt == BEAT_LAST) begin
                beat_cnt  <= '0;
                drain_cnt <= '0;
                state     <= DRAIN;
              end else begin
                beat_cnt <= beat_cnt + 1'b1;
              end
            end else begin
              mac_en <= 1'b0;
            end
          end

          DRAIN: begin
            mac_en <= 1'b0;
            if (drain_cnt == DRAIN_LAST) begin
              drain_cnt <= '0;
              res_data  <= mac_cout;
              res_valid <= 1'b1;
              state     <= RESULT;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end

          RESULT: begin
            mac_en <= 1'b0;
            if (res_ready) begin
              res_valid <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end

          default: begin
            state  <= IDLE;
            mac_en <= 1'b0;
          end
        endcase
      end
    end
  end

  // RES_W is used only to document the result width.
  logic unused_ok;
  assign unused_ok = (RES_W == $bits(res_data));

endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder
//
// Bench for mac_feeder with DATA_WIDTH=8, VEC_LEN=4 and PIPELINE_DELAY=1.
// A small behavioural MAC (one product stage plus a Cout register) closes
// the loop. The expected results come from a plain dot product of the
// operand vectors each job offers.

`timescale 1ns/1ps

module tb_mac_feeder;

  localparam int DW = 8;
  localparam int VL = 4;
  localparam int PD = 1;
  localparam int RW = 3 * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [DW-1:0] a_data = '0;
  logic          b_valid = 1'b0;
  logic          b_ready;
  logic [DW-1:0] b_data = '0;
  logic          mac_en;
  logic          mac_clr;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic [RW-1:0] mac_cout = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [RW-1:0] res_data;
  logic          done;
`ifdef MAC_FEEDER_ABORT_EN
  logic          abort = 1'b0;
  logic          aborted;
`endif

  int errCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  mac_feeder #(
    .DATA_WIDTH(DW),
    .VEC_LEN(VL),
    .PIPELINE_DELAY(PD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .busy(busy),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .a_data(a_data),
    .b_valid(b_valid),
    .b_ready(b_ready),
    .b_data(b_data),
    .mac_en(mac_en),
    .mac_clr(mac_clr),
    .mac_a(mac_a),
    .mac_b(mac_b),
    .mac_cout(mac_cout),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .done(done)
`ifdef MAC_FEEDER_ABORT_EN
    ,
    .abort(abort),
    .aborted(aborted)
`endif
  );

  // Behavioural MAC: the product is registered after En, then accumulated into Cout.
  // The MAC is deliberately not tied to rst_n; only Clr can empty it.
  logic [RW-1:0] stage_q = '0;
  always @(posedge clk) begin
    stage_q  <= mac_en ? (RW'(mac_a) * RW'(mac_b)) : '0;
    mac_cout <= mac_clr ? '0 : (mac_cout + stage_q);
  end

  // Free-running monitors. Each job uses differences of these counters.
  int cyc = 0;
  int enCount = 0;
  int clrCount = 0;
  int aHsCount = 0;
  int bHsCount = 0;
  int orphanCount = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mac_en) enCount <= enCount + 1;
    if (mac_clr) clrCount <= clrCount + 1;
    if (a_valid && a_ready) aHsCount <= aHsCount + 1;
    if (b_valid && b_ready) bHsCount <= bHsCount + 1;
    if ((a_ready || b_ready) && !(a_valid && b_valid)) orphanCount <= orphanCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pickValid(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 2) == 0;
    return $urandom_range(0, 1) == 1;
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_a_ready"}, a_ready, 0);
    checkOutput({tag, "_b_ready"}, b_ready, 0);
    checkOutput({tag, "_mac_en"}, mac_en, 0);
    checkOutput({tag, "_mac_clr"}, mac_clr, 0);
    checkOutput({tag, "_mac_a"}, mac_a, 0);
    checkOutput({tag, "_mac_b"}, mac_b, 0);
    checkOutput({tag, "_res_valid"}, res_valid, 0);
    checkOutput({tag, "_res_data"}, res_data, 0);
    checkOutput({tag, "_done"}, done, 0);
  endtask

  // Runs one whole job from the current cycle. The caller must leave the DUT idle.
  task automatic applyStimulus(input logic [DW-1:0] av[VL], input logic [DW-1:0] bv[VL],
                               input int aMode, input int bMode, input int holdCycles,
                               input bit checkLat, input bit backToBack, input string tag);
    logic [DW-1:0] aq[$];
    logic [DW-1:0] bq[$];
    logic [RW-1:0] expRes;
    logic [RW-1:0] firstRes;
    int en0, clr0, a0, b0, orph0;
    int held, tRes, t0;
    bit gotRes, accepted, hsA, hsB;
    expRes = '0;
    firstRes = '0;
    held = 0;
    tRes = 0;
    gotRes = 0;
    accepted = 0;
    for (int i = 0; i < VL; i++) begin
      aq.push_back(av[i]);
      bq.push_back(bv[i]);
      expRes += RW'(av[i]) * RW'(bv[i]);
    end
    en0 = enCount; clr0 = clrCount; a0 = aHsCount; b0 = bHsCount; orph0 = orphanCount;
    start = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 400 && !accepted; k++) begin
      if (k > 0) start = 1'b0;
      a_valid = (aq.size() > 0) && pickValid(aMode, k);
      a_data  = (aq.size() > 0) ? aq[0] : '0;
      b_valid = (bq.size() > 0) && pickValid(bMode, k);
      b_data  = (bq.size() > 0) ? bq[0] : '0;
      if (res_valid && held < holdCycles) begin
        res_ready = 1'b0;
        start = 1'b1;
        held++;
      end else if (res_valid) begin
        res_ready = 1'b1;
      end else begin
        res_ready = ($urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      if (gotRes) begin
        checkOutput({tag, "_res_valid_held"}, res_valid, 1);
        checkOutput({tag, "_res_stable"}, res_data, firstRes);
        checkOutput({tag, "_busy_result"}, busy, 1);
      end else if (res_valid) begin
        gotRes = 1;
        tRes = cyc;
        firstRes = res_data;
        checkOutput({tag, "_res_data"}, res_data, expRes);
        if (checkLat) checkOutput({tag, "_latency"}, tRes - t0, VL + PD + 4);
      end
      if (k > 0) checkOutput({tag, "_done_early"}, done, 0);
      accepted = res_valid && res_ready;
      hsA = a_valid && a_ready;
      hsB = b_valid && b_ready;
      @(posedge clk);
      #1;
      if (hsA && aq.size() > 0) void'(aq.pop_front());
      if (hsB && bq.size() > 0) void'(bq.pop_front());
    end
    start = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    res_ready = 1'b0;
    if (!accepted) checkOutput({tag, "_timeout"}, 0, 1);
    checkOutput({tag, "_done_pulse"}, done, 1);
    checkOutput({tag, "_res_valid_cleared"}, res_valid, 0);
    checkOutput({tag, "_idle"}, busy, 0);
    checkOutput({tag, "_en_count"}, enCount - en0, VL);
    checkOutput({tag, "_clr_count"}, clrCount - clr0, 1);
    checkOutput({tag, "_a_beats"}, aHsCount - a0, VL);
    checkOutput({tag, "_b_beats"}, bHsCount - b0, VL);
    checkOutput({tag, "_orphan"}, orphanCount - orph0, 0);
    if (!backToBack) begin
      waitCycle();
      checkOutput({tag, "_done_one_cycle"}, done, 0);
    end
  endtask

  logic [DW-1:0] va[VL];
  logic [DW-1:0] vb[VL];
  logic [DW-1:0] ones[VL];

  initial begin
    $display("[TB] mac_feeder bench start");
    a_valid = 1'b1;
    b_valid = 1'b1;
    repeat (3) waitCycle();
    checkResetState("por");
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst_n = 1'b1;
    waitCycle();

    va = '{8'd1, 8'd2, 8'd3, 8'd4};
    vb = '{8'd5, 8'd6, 8'd7, 8'd8};
    ones = '{8'd1, 8'd1, 8'd1, 8'd1};

    applyStimulus(va, vb, 0, 0, 0, 1'b1, 1'b0, "basic");
    applyStimulus('{8'd255, 8'd255, 8'd255, 8'd255}, '{8'd255, 8'd255, 8'd255, 8'd255},
                  0, 0, 0, 1'b1, 1'b0, "max");
    applyStimulus(va, vb, 1, 0, 0, 1'b0, 1'b0, "stall_a");
    applyStimulus(va, vb, 0, 0, 10, 1'b1, 1'b0, "backpressure");
    applyStimulus(va, vb, 0, 0, 0, 1'b1, 1'b1, "b2b_job1");
    applyStimulus(ones, ones, 0, 0, 0, 1'b1, 1'b0, "b2b_job2");

    // An asynchronous reset after two FEED beats must abort the job at once.
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data = 8'd9;
    b_data = 8'd3;
    start = 1'b1;
    waitCycle();
    start = 1'b0;
    repeat (3) waitCycle();
    checkOutput("pre_reset_busy", busy, 1);
    checkOutput("pre_reset_mac_en", mac_en, 1);
    #1 rst_n = 1'b0;
    #1 checkResetState("async_rst");
    waitCycle();
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst_n = 1'b1;
    waitCycle();
    applyStimulus(va, vb, 0, 0, 0, 1'b1, 1'b0, "after_reset");

`ifdef MAC_FEEDER_ABORT_EN
    // Cancel the job in its second DRAIN cycle.
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data = 8'd7;
    b_data = 8'd7;
    start = 1'b1;
    waitCycle();
    start = 1'b0;
    repeat (6) waitCycle();
    checkOutput("pre_abort_busy", busy, 1);
    checkOutput("pre_abort_res_valid", res_valid, 0);
    abort = 1'b1;
    waitCycle();
    abort = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    checkOutput("abort_aborted", aborted, 1);
    checkOutput("abort_idle", busy, 0);
    checkOutput("abort_clr", mac_clr, 1);
    checkOutput("abort_res_valid", res_valid, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_mac_en", mac_en, 0);
    waitCycle();
    checkOutput("abort_pulse_one_cycle", aborted, 0);
    for (int i = 0; i < 3; i++) begin
      waitCycle();
      checkOutput("abort_no_result", res_valid, 0);
    end
    applyStimulus(va, vb, 0, 0, 0, 1'b1, 1'b0, "after_abort");
`endif

    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < VL; i++) begin
        va[i] = DW'($urandom_range(0, 255));
        vb[i] = DW'($urandom_range(0, 255));
      end
      applyStimulus(va, vb, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)), 1'b0, 1'b0, "random");
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
